approx_adder_err_monitor: RTL and testbench

Exhaustive error-checking stage for generated approximate adder netlists. Upstream, it drives every input vector into the approximate adder's `in*` pins. Downstream, it consumes the adder's `out*` pins, compares each result with the exact sum, and accumulates worst-case error, a violation count and a pass/fail verdict against the error threshold. It sits in the verification wrapper around each synthesized `adder_i*_o*` candidate, so one run validates one approximation.

---
 rtl/approx_adder_err_monitor.sv | 162 ++++++++++++++++
 tb/tb_approx_adder_err_monitor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : approx_adder_err_monitor
// Purpose  : Exhaustive error checker for an approximate adder candidate.
//            Sweeps every input vector into the adder, compares the adder's
//            combinational result with the exact sum, and accumulates the
//            worst-case error, the first vector that produced it, the number
//            of vectors whose error exceeds ET, and a pass/fail verdict.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_IN   : total adder input bits (even); A = vec_out[N_IN/2-1:0],
//            B = vec_out[N_IN-1:N_IN/2]
//   N_OUT  : adder output bits, N_IN/2+1
//   ET     : error threshold; a vector violates when |error| > ET
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a sweep (honoured only in IDLE)
//   vec_out    out  registered stimulus to the adder inputs
//   approx_in  in   combinational adder result for vec_out
//   busy       out  high while sweeping
//   done       out  one-cycle pulse when a sweep ends
//   pass       out  max_err <= ET
//   max_err    out  largest absolute error seen
//   worst_vec  out  first vector that produced max_err
//   err_count  out  number of violating vectors
// Build option
//   ERR_EARLY_ABORT_EN : when defined, the first violating vector ends the
//                        sweep (vec_out holds that vector).
// ============================================================================
module approx_adder_err_monitor #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int ET    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  vec_out,
  input  logic [N_OUT-1:0] approx_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] max_err,
  output logic [N_IN-1:0]  worst_vec,
  output logic [N_IN:0]    err_count
);

  localparam int HALF = N_IN / 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [31:0]     ET_U     = 32'(ET);

  logic [1:0]       state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [N_OUT-1:0] max_q, max_d;
  logic [N_IN-1:0]  worst_q, worst_d;
  logic [N_IN:0]    cnt_q, cnt_d;

  logic [HALF-1:0]  op_a;
  logic [HALF-1:0]  op_b;
  logic [N_OUT-1:0] exact_sum;
  logic [N_OUT-1:0] abs_err;
  logic             err_viol;
  logic             err_greater;

  assign op_a = vec_q[HALF-1:0];
  assign op_b = vec_q[N_IN-1:HALF];

  // N_OUT = HALF+1 bits hold the largest exact sum without overflow.
  assign exact_sum = N_OUT'(op_a) + N_OUT'(op_b);

  // Magnitude of the difference; subtracting the smaller operand from the
  // larger keeps it inside N_OUT bits without a sign bit.
  assign abs_err = (exact_sum >= approx_in) ? (exact_sum - approx_in)
                                            : (approx_in - exact_sum);

  assign err_viol    = (32'(abs_err) > ET_U);
  assign err_greater = (abs_err > max_q);   // strict: ties keep earlier vector

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    max_d   = max_q;
    worst_d = worst_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          vec_d   = '0;
          max_d   = '0;
          worst_d = '0;
          cnt_d   = '0;
        end
      end

      S_SWEEP: begin
        if (err_greater) begin
          max_d   = abs_err;
          worst_d = vec_q;
        end
        if (err_viol) begin
          cnt_d = cnt_q + (N_IN+1)'(1);
        end
`ifdef ERR_EARLY_ABORT_EN
        if (err_viol || (vec_q == VEC_LAST)) begin
          state_d = S_DONE;       // vec_out keeps the terminating vector
        end else begin
          vec_d = vec_q + N_IN'(1);
        end
`else
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;       // all-ones vector stays on vec_out
        end else begin
          vec_d = vec_q + N_IN'(1);
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      max_q   <= '0;
      worst_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      max_q   <= max_d;
      worst_q <= worst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign vec_out   = vec_q;
  assign busy      = (state_q == S_SWEEP);
  assign done      = (state_q == S_DONE);
  assign pass      = (32'(max_q) <= ET_U);
  assign max_err   = max_q;
  assign worst_vec = worst_q;
  assign err_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_adder_err_monitor
// Purpose  : Self-checking bench for approx_adder_err_monitor with default
//            parameters. A behavioural adder stands in for the candidate
//            netlist (exact, constant, stuck-at and random lookup models).
//            Fixed models are checked from a constant table; random models
//            are checked against a whole-sweep reference computed here.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_adder_err_monitor;

  localparam int TB_ET = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] vec_out;
  logic [2:0] approx_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] max_err;
  logic [3:0] worst_vec;
  logic [4:0] err_count;

  int         mode;
  logic [2:0] rand_tab [16];

  int total = 0;
  int bad   = 0;

  approx_adder_err_monitor #(.N_IN(4), .N_OUT(3), .ET(TB_ET)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_out   (vec_out),
    .approx_in (approx_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .max_err   (max_err),
    .worst_vec (worst_vec),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder candidate driven by the current stimulus vector.
  always_comb begin
    case (mode)
      0:       approx_in = 3'(int'(vec_out[1:0]) + int'(vec_out[3:2]));
      1:       approx_in = 3'd3;
      2:       approx_in = 3'd0;
      3:       approx_in = rand_tab[vec_out];
      default: approx_in = 3'd7;
    endcase
  end

  function automatic int approx_of(int m, int v);
    case (m)
      0:       return (v % 4) + (v / 4);
      1:       return 3;
      2:       return 0;
      3:       return int'(rand_tab[v]);
      default: return 7;
    endcase
  endfunction

  // Whole-sweep expectation straight from the error rules.
  task automatic model(input int m, output int mx, output int wv,
                       output int cnt, output int ps, output int dcyc,
                       output int vfin);
    int e;
    mx = 0; wv = 0; cnt = 0; dcyc = 17; vfin = 15;
    for (int v = 0; v < 16; v++) begin
      e = (v % 4) + (v / 4) - approx_of(m, v);
      if (e < 0) e = -e;
      if (e > mx) begin mx = e; wv = v; end
      if (e > TB_ET) begin
        cnt++;
`ifdef ERR_EARLY_ABORT_EN
        dcyc = v + 2;
        vfin = v;
        break;
`endif
      end
    end
    ps = (mx <= TB_ET) ? 1 : 0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pulse start in cycle 0, then watch cycles 1.. until two cycles past done
  // (bounded at 40 cycles; an expired bound leaves dcyc at -1).
  task automatic run_sweep(output int dcyc, output int busy_n,
                           output int done_n, output int seq_ok);
    int cyc;
    dcyc = -1; busy_n = 0; done_n = 0; seq_ok = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (cyc <= 40) begin
      if (busy) begin
        busy_n++;
        if (int'(vec_out) != cyc - 1) seq_ok = 0;
      end
      if (done) begin
        done_n++;
        if (dcyc < 0) dcyc = cyc;
      end
      if (dcyc >= 0 && cyc >= dcyc + 2) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    int mode;
    int mx;
    int wv;
    int cnt;
    int ps;
    int dcyc;
    int vfin;
  } vec_t;

  vec_t tab [4];

  task automatic check_results(input string tag, input int mx, input int wv,
                               input int cnt, input int ps, input int dcyc,
                               input int vfin);
    int d, bn, dn, ok;
    run_sweep(d, bn, dn, ok);
    chk({tag, " done_cycle"}, d, dcyc);
    chk({tag, " busy_cycles"}, bn, dcyc - 1);
    chk({tag, " done_pulses"}, dn, 1);
    chk({tag, " vec_sequence"}, ok, 1);
    chk({tag, " max_err"}, int'(max_err), mx);
    chk({tag, " worst_vec"}, int'(worst_vec), wv);
    chk({tag, " err_count"}, int'(err_count), cnt);
    chk({tag, " pass"}, int'(pass), ps);
    chk({tag, " vec_final"}, int'(vec_out), vfin);
  endtask

  initial begin
    int mx, wv, cnt, ps, dcyc, vfin;
    int dn, b18, b19, got;

    // mode, max_err, worst_vec, err_count, pass, done cycle, final vec_out
    tab[0] = '{0, 0,  0, 0, 1, 17, 15};
    tab[1] = '{1, 3,  0, 0, 1, 17, 15};
`ifdef ERR_EARLY_ABORT_EN
    tab[2] = '{2, 5, 11, 1, 0, 13, 11};
    tab[3] = '{4, 7,  0, 1, 0,  2,  0};
`else
    tab[2] = '{2, 6, 15, 3, 0, 17, 15};
    tab[3] = '{4, 7,  0, 6, 0, 17, 15};
`endif

    mode  = 0;
    rst   = 1'b1;
    start = 1'b0;
    for (int v = 0; v < 16; v++) rand_tab[v] = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset vec_out", int'(vec_out), 0);
    chk("reset max_err", int'(max_err), 0);
    chk("reset worst_vec", int'(worst_vec), 0);
    chk("reset err_count", int'(err_count), 0);
    chk("reset pass", int'(pass), 1);

    for (int i = 0; i < 4; i++) begin
      mode = tab[i].mode;
      check_results($sformatf("tab%0d", i), tab[i].mx, tab[i].wv, tab[i].cnt,
                    tab[i].ps, tab[i].dcyc, tab[i].vfin);
      repeat (3) @(negedge clk);
      chk($sformatf("tab%0d held max_err", i), int'(max_err), tab[i].mx);
    end

    for (int it = 0; it < 6; it++) begin
      for (int v = 0; v < 16; v++) rand_tab[v] = 3'($urandom_range(0, 7));
      mode = 3;
      model(3, mx, wv, cnt, ps, dcyc, vfin);
      check_results($sformatf("rand%0d", it), mx, wv, cnt, ps, dcyc, vfin);
    end

    // start held high: one sweep, restart only once back in IDLE.
    mode = 0;
    dn = 0; b18 = -1;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (done) dn++;
      if (c == 18) b18 = int'(busy);
    end
    @(negedge clk);
    b19 = int'(busy);
    start = 1'b0;
    chk("held done_pulses", dn, 1);
    chk("held busy_cycle18", b18, 0);
    chk("held busy_cycle19", b19, 1);
    got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk("held second_done", got, 1);
    repeat (2) @(negedge clk);

    // Reset in cycle 6 of a sweep.
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst pre max_err", int'(max_err), 3);
    chk("rst pre busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst busy", int'(busy), 0);
    chk("rst vec_out", int'(vec_out), 0);
    chk("rst err_count", int'(err_count), 0);
    chk("rst max_err", int'(max_err), 0);
    dn = int'(done);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("rst no_done", dn, 0);
    check_results("post_rst", 3, 0, 0, 1, 17, 15);

    // rst and start together: reset wins.
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    chk("rst_start busy", int'(busy), 0);
    chk("rst_start max_err", int'(max_err), 0);
    @(negedge clk);
    chk("rst_start busy_later", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
